eth_tx_arbiter: RTL and testbench

- Packet-granular arbiter sharing one 64-bit Ethernet MAC TX stream between two sources.
- Port 0 is the CHDR/IPv4 adapter egress; port 1 is the CPU egress (c2e path).
- Sits between those sources and the MAC.
- Provides weighted round-robin with a starvation bound, per-packet length enforcement (truncation at MTU), one registered output stage, and packet/truncation counters for register readback.

---
 rtl/eth_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Packet-granular two-port arbiter feeding one 64-bit MAC TX stream.
// Weighted round-robin grant, MTU truncation, one registered output stage and status counters.
module eth_tx_arbiter #(
    parameter int MTU     = 10,
    parameter int WEIGHT0 = 4,
    parameter int WEIGHT1 = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [63:0]      s0_tdata,
    input  logic [3:0]       s0_tuser,
    input  logic             s0_tlast,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [63:0]      s1_tdata,
    input  logic [3:0]       s1_tuser,
    input  logic             s1_tlast,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    output logic [63:0]      m_tdata,
    output logic [3:0]       m_tuser,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic [1:0]       active_port
);

    typedef enum logic [2:0] {IDLE, PASS0, PASS1, DROP0, DROP1} state_t;

    state_t             state_q, state_d;
    logic               last_q;
    logic [3:0]         cons_cnt_q;
    logic [MTU-1:0]     beat_cnt_q;
    logic [63:0]        m_tdata_q;
    logic [3:0]         m_tuser_q;
    logic               m_tlast_q;
    logic               m_tvalid_q;
    logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt1_q, trunc_cnt_q;

    logic               both_req, grant_vld, grant1, stay;
    logic [3:0]         last_weight;
    logic               load_en, sel, pass, drop, rdy, acc;
    logic [63:0]        in_data;
    logic [3:0]         in_user;
    logic               in_last, in_valid, at_max, trunc, pkt_done;

    // Grant decision used only in IDLE. A zero count means nothing has been
    // served yet, so the pointer alone decides and port 0 wins the first tie.
    assign both_req    = s0_tvalid && s1_tvalid;
    assign grant_vld   = s0_tvalid || s1_tvalid;
    assign last_weight = last_q ? 4'(WEIGHT1) : 4'(WEIGHT0);
    assign stay        = (cons_cnt_q != 4'd0) && (cons_cnt_q < last_weight);
    assign grant1      = both_req ? (stay ? last_q : !last_q) : s1_tvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:         if (grant_vld) state_d = grant1 ? PASS1 : PASS0;
            PASS0, PASS1: if (acc && in_last) state_d = IDLE;
                          else if (trunc) state_d = sel ? DROP1 : DROP0;
            DROP0, DROP1: if (acc && in_last) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        sel         = (state_q == PASS1) || (state_q == DROP1);
        pass        = (state_q == PASS0) || (state_q == PASS1);
        drop        = (state_q == DROP0) || (state_q == DROP1);
        load_en     = !m_tvalid_q || m_tready;
        rdy         = pass ? load_en : drop;
        s0_tready   = rdy && !sel;
        s1_tready   = rdy && sel;
        in_valid    = sel ? s1_tvalid : s0_tvalid;
        in_data     = sel ? s1_tdata  : s0_tdata;
        in_user     = sel ? s1_tuser  : s0_tuser;
        in_last     = sel ? s1_tlast  : s0_tlast;
        acc         = rdy && in_valid;
        at_max      = (beat_cnt_q == '1);
        trunc       = pass && acc && at_max && !in_last;
        pkt_done    = pass && acc && (in_last || at_max);
        active_port = {sel && (pass || drop), !sel && (pass || drop)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= 1'b1;
            cons_cnt_q <= '0;
        end else if (state_q == IDLE && grant_vld) begin
            // NOTE: sequential state always uses non-blocking assignment.
            last_q <= grant1;
            if (grant1 != last_q)  cons_cnt_q <= 4'd1;
            else if (both_req)     cons_cnt_q <= cons_cnt_q + 4'd1;
        end
    end

    // Output data is reset too, since the MAC-facing flops must read 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            if (pass && acc) begin
                beat_cnt_q <= (in_last || at_max) ? '0 : beat_cnt_q + 1'b1;
                m_tdata_q  <= in_data;
                m_tuser_q  <= trunc ? 4'd0 : in_user;
                m_tlast_q  <= in_last || trunc;
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt0_q  <= '0;
            pkt_cnt1_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (pkt_done && !sel) pkt_cnt0_q  <= pkt_cnt0_q + 1'b1;
            if (pkt_done && sel)  pkt_cnt1_q  <= pkt_cnt1_q + 1'b1;
            if (trunc)            trunc_cnt_q <= trunc_cnt_q + 1'b1;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tuser   = m_tuser_q;
    assign m_tlast   = m_tlast_q;
    assign m_tvalid  = m_tvalid_q;
    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter (MTU = 4): ordering, fairness, truncation,
// back-pressure scoreboard and mid-packet reset.
module tb_eth_tx_arbiter;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 500;

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [63:0]      s0_tdata = '0, s1_tdata = '0;
    logic [3:0]       s0_tuser = '0, s1_tuser = '0;
    logic             s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic             s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic             s0_tready, s1_tready;
    logic [63:0]      m_tdata;
    logic [3:0]       m_tuser;
    logic             m_tlast, m_tvalid;
    logic             m_tready = 1'b1;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1, trunc_cnt;
    logic [1:0]       active_port;

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  rand_ready = 1'b0;
    logic  check_lat  = 1'b0;
    int    s1_rdy_cnt = 0;
    beat_t out_q[$];
    beat_t exp0[$], exp1[$];

    eth_tx_arbiter #(.MTU(4), .WEIGHT0(4), .WEIGHT1(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_tdata(s0_tdata), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt),
        .active_port(active_port)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // A beat seen valid&&ready at the falling edge transfers on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && m_tvalid && m_tready) out_q.push_back('{m_tdata, m_tuser, m_tlast});
        if (s1_tready) s1_rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input int p, input int id, input int b);
        return {8'hA0 | 8'(p), 24'(id), 32'(b)};
    endfunction

    task automatic do_reset();
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_q.delete();
    endtask

    task automatic send_beat(input int p, input logic [63:0] d, input logic [3:0] u, input logic l);
        int   t = 0;
        logic r = 1'b0;
        if (p == 0) begin s0_tdata = d; s0_tuser = u; s0_tlast = l; s0_tvalid = 1'b1; end
        else        begin s1_tdata = d; s1_tuser = u; s1_tlast = l; s1_tvalid = 1'b1; end
        forever begin
            @(negedge clk);
            r = (p == 0) ? s0_tready : s1_tready;
            if (r || t >= TIMEOUT) break;
            t++;
        end
        if (!r) begin
            n_checks++;
            n_fail++;
            $error("FAIL handshake_timeout: port %0d tready observed 0 expected 1", p);
        end
        @(posedge clk);
        #1;
        if (p == 0) s0_tvalid = 1'b0;
        else        s1_tvalid = 1'b0;
        if (check_lat) chk("latency_data", m_tdata, d);
    endtask

    task automatic send_pkt(input int p, input int id, input int n, input logic [3:0] u);
        for (int b = 0; b < n; b++)
            send_beat(p, mkdata(p, id, b), (b == n - 1) ? u : 4'd0, b == n - 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        repeat (3) @(negedge clk);
        while (m_tvalid && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (m_tvalid) begin
            n_checks++;
            n_fail++;
            $error("FAIL drain_timeout: m_tvalid observed 1 expected 0");
        end
    endtask

    task automatic push_exp(input int p, input int id, input int n, input logic [3:0] u);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = '{mkdata(p, id, i), (i == n - 1) ? u : 4'd0, i == n - 1};
            if (p == 0) exp0.push_back(b);
            else        exp1.push_back(b);
        end
    endtask

    initial begin
        int    exp_src[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int    snap;
        beat_t b, e;
        logic  prev_src, mid_pkt;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_active", active_port, 0);
        chk("rst_cnts", {pkt_cnt0, pkt_cnt1} | trunc_cnt, 0);

        // Port 0 alone: three 4-beat packets, 1-cycle latency checked per beat
        snap = s1_rdy_cnt;
        check_lat = 1'b1;
        for (int k = 0; k < 3; k++) send_pkt(0, k, 4, 4'd2);
        check_lat = 1'b0;
        wait_drain();
        chk("t1_beats", out_q.size(), 12);
        for (int i = 0; i < 12 && i < out_q.size(); i++) begin
            chk("t1_data", out_q[i].d, mkdata(0, i / 4, i % 4));
            chk("t1_last", out_q[i].l, (i % 4) == 3);
        end
        chk("t1_pkt_cnt0", pkt_cnt0, 3);
        chk("t1_s1_tready", s1_rdy_cnt - snap, 0);

        // Both ports contend with 2-beat packets: 4:1 weighting
        do_reset();
        fork
            for (int k = 0; k < 8; k++) send_pkt(0, 10 + k, 2, 4'd1);
            for (int k = 0; k < 2; k++) send_pkt(1, 20 + k, 2, 4'd1);
        join
        wait_drain();
        chk("t2_beats", out_q.size(), 20);
        for (int k = 0; k < 10 && 2 * k + 1 < out_q.size(); k++) begin
            chk("t2_src_first", out_q[2*k].d[56], exp_src[k]);
            chk("t2_src_second", out_q[2*k+1].d[56], exp_src[k]);
            chk("t2_last", out_q[2*k+1].l, 1);
        end

        // Port 1 oversize packet: 21 beats, truncated at 16
        do_reset();
        send_pkt(1, 30, 21, 4'd5);
        wait_drain();
        chk("t3_beats", out_q.size(), 16);
        if (out_q.size() == 16) begin
            chk("t3_beat15_data", out_q[15].d, mkdata(1, 30, 15));
            chk("t3_beat15_last", out_q[15].l, 1);
            chk("t3_beat15_user", out_q[15].u, 0);
            chk("t3_beat14_last", out_q[14].l, 0);
        end
        chk("t3_trunc_cnt", trunc_cnt, 1);
        chk("t3_pkt_cnt1", pkt_cnt1, 1);
        chk("t3_active", active_port, 0);

        // Exactly 2**MTU beats with tlast on the final beat: legal
        do_reset();
        send_pkt(0, 40, 16, 4'd3);
        wait_drain();
        chk("t4_beats", out_q.size(), 16);
        if (out_q.size() == 16) begin
            chk("t4_last_user", out_q[15].u, 3);
            chk("t4_last_flag", out_q[15].l, 1);
        end
        chk("t4_trunc_cnt", trunc_cnt, 0);
        chk("t4_pkt_cnt0", pkt_cnt0, 1);

        // Random back-pressure with interleaved offers, scoreboarded per port
        do_reset();
        exp0.delete();
        exp1.delete();
        push_exp(0, 50, 3, 4'd1); push_exp(0, 51, 1, 4'd7); push_exp(0, 52, 5, 4'd0);
        push_exp(1, 53, 2, 4'd3); push_exp(1, 54, 4, 4'd0); push_exp(1, 55, 3, 4'd5);
        rand_ready = 1'b1;
        fork
            begin send_pkt(0, 50, 3, 4'd1); send_pkt(0, 51, 1, 4'd7); send_pkt(0, 52, 5, 4'd0); end
            begin send_pkt(1, 53, 2, 4'd3); send_pkt(1, 54, 4, 4'd0); send_pkt(1, 55, 3, 4'd5); end
        join
        wait_drain();
        rand_ready = 1'b0;
        chk("t5_beats", out_q.size(), 18);
        mid_pkt  = 1'b0;
        prev_src = 1'b0;
        while (out_q.size() > 0) begin
            b = out_q.pop_front();
            if (mid_pkt) chk("t5_no_interleave", b.d[56], prev_src);
            if ((b.d[56] ? exp1.size() : exp0.size()) == 0) begin
                chk("t5_extra_beat", b.d, 0);
            end else begin
                e = b.d[56] ? exp1.pop_front() : exp0.pop_front();
                chk("t5_beat", b, e);
            end
            prev_src = b.d[56];
            mid_pkt  = !b.l;
        end
        chk("t5_missing", exp0.size() + exp1.size(), 0);
        chk("t5_pkt_cnt0", pkt_cnt0, 3);

        // Reset asserted after beat 3 of an 8-beat packet
        m_tready = m_tready;
        for (int i = 0; i < 3; i++) send_beat(0, mkdata(0, 60, i), 4'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6_m_tvalid", m_tvalid, 0);
        chk("t6_m_tdata", m_tdata, 0);
        chk("t6_pkt_cnt0", pkt_cnt0, 0);
        chk("t6_pkt_cnt1", pkt_cnt1, 0);
        chk("t6_active", active_port, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_q.delete();
        fork
            send_pkt(0, 61, 1, 4'd0);
            send_pkt(1, 62, 1, 4'd0);
        join
        wait_drain();
        chk("t6_beats", out_q.size(), 2);
        if (out_q.size() > 0) chk("t6_first_tie", out_q[0].d, mkdata(0, 61, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
